// File: rtl/mult_booth_n.sv
// ---------------------------------------------------------------------------
// mult_booth_n
//
// Multicycle radix-2 Booth multiplier for the HI/LO unit. Handles both
// signed (MULT) and unsigned (MULTU) operands through a per-operation mode
// bit. One Booth step is retired per clock over WIDTH+1 bits of the
// extended multiplier. The block accepts back-to-back operations and can
// be aborted cleanly.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   mult_start : request a multiply (sampled on a rising edge)
//   is_signed  : 1 = signed operands, 0 = unsigned (sampled with mult_start)
//   mult_abort : synchronous cancel of the operation in flight
//   A, B       : multiplicand / multiplier (sampled with mult_start)
//   hi, lo     : registered upper / lower halves of the product
//   mult_end   : one-cycle pulse; hi/lo are valid in the same cycle
//   busy       : high while iterating
// ---------------------------------------------------------------------------
module mult_booth_n #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_start,
    input  logic             is_signed,
    input  logic             mult_abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_end,
    output logic             busy
);

    localparam int EXT_W = WIDTH + 1;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One radix-2 Booth recoding step: the bit pair {b[i], b[i-1]} selects
    // subtract, add or hold of the already-shifted multiplicand.
    function automatic logic signed [ACC_W-1:0] f_booth_step(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] madd,
        input logic [1:0]              pair
    );
        logic signed [ACC_W-1:0] res;
        case (pair)
            2'b10:   res = acc - madd;
            2'b01:   res = acc + madd;
            default: res = acc;
        endcase
        return res;
    endfunction

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    // Multiplicand, sign-extended to the accumulator width and shifted left
    // one place per step, so step i always sees ext_A << i.
    logic signed [ACC_W-1:0] r_ma;
    // Multiplier, shifted right one place per step; bit 0 is b[i].
    logic [EXT_W-1:0]        r_mb;
    // b[i-1]; starts as the implicit bit -1 = 0.
    logic                    r_prev;
    logic [CNT_W-1:0]        r_cnt;
    logic [WIDTH-1:0]        r_hi;
    logic [WIDTH-1:0]        r_lo;
    logic                    r_end;
    logic                    r_busy;

    logic [EXT_W-1:0]        w_ext_a;
    logic [EXT_W-1:0]        w_ext_b;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_last;
    logic                    w_accept;

    // Extension to WIDTH+1 bits makes both modes a plain signed multiply:
    // unsigned operands gain a zero sign bit.
    assign w_ext_a    = {is_signed & A[WIDTH-1], A};
    assign w_ext_b    = {is_signed & B[WIDTH-1], B};
    assign w_acc_next = f_booth_step(r_acc, r_ma, {r_mb[0], r_prev});
    assign w_last     = (r_cnt == CNT_W'(WIDTH));
    // Abort beats start when both are present outside RUN.
    assign w_accept   = mult_start & ~mult_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_end   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_ma    <= {{(WIDTH + 1){w_ext_a[WIDTH]}}, w_ext_a};
                        r_mb    <= w_ext_b;
                        r_prev  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (mult_abort) begin
                        // Abort outranks the final step: hi/lo stay put.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc  <= w_acc_next;
                        r_ma   <= r_ma << 1;
                        r_mb   <= r_mb >> 1;
                        r_prev <= r_mb[0];
                        if (w_last) begin
                            // Product of the extended operands, low 2*WIDTH bits.
                            r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                            r_lo    <= w_acc_next[WIDTH-1:0];
                            r_end   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mult_end = r_end;
    assign busy     = r_busy;

endmodule
